// File: rtl/mips_controller.sv
// mips_controller
// Multicycle control unit for the 8-bit MIPS datapath. It sequences the
// byte-serial fetch, decode, execute, memory and write-back steps. It decodes
// the ALU operation for R-type instructions.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset, forces FETCH1
//   op, funct  - instruction opcode / function fields from the datapath
//   zero       - ALU result-is-zero flag, used only to qualify branches
//   memread, memwrite, iord                - memory strobes and address select
//   irwrite                                - instruction byte enables (bit0 = instr[31:24])
//   alusrca, alusrcb, alucontrol           - ALU operand selects and operation
//   pcsource, pcen                         - next-PC select and PC enable
//   regwrite, regdst, memtoreg             - register file write controls
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
        MEMADR, LBRD, LBWR, SBWR,
        RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state, next_state;
    logic   pcwrite, branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = '0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        pcsource   = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;

        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                iord    = 1'b1;
                alusrca = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                case (state)
                    FETCH1:  begin irwrite = 4'b0001; next_state = FETCH2; end
                    FETCH2:  begin irwrite = 4'b0010; next_state = FETCH3; end
                    FETCH3:  begin irwrite = 4'b0100; next_state = FETCH4; end
                    default: begin irwrite = 4'b1000; next_state = DECODE; end
                endcase
            end
            DECODE: begin
                // Branch target (PC + offset*4) is computed here into aluout.
                alusrca = 1'b1;
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH1;
                endcase
            end
            MEMADR: begin
                alusrcb    = 2'b10;
                next_state = (op == OP_SB) ? SBWR : LBRD;
            end
            LBRD: begin
                memread    = 1'b1;
                next_state = LBWR;
            end
            LBWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
                next_state = RTYPEWR;
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            BEQEX: begin
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsource   = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIEX: begin
                alusrcb    = 2'b10;
                next_state = ADDIWR;
            end
            ADDIWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                memtoreg = 1'b1;
            end
            default: next_state = FETCH1;
        endcase
    end

    // zero is combinational here so a taken beq loads the PC in BEQEX itself.
    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller
// Self-checking bench for mips_controller: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a per-instruction
// behavioural model indexed by cycle number within the instruction.
module tb_mips_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsource;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
    } ctl_t;

    localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucontrol;
    ctl_t       cur;

    int checks = 0;
    int errors = 0;

    ctl_t obs[$];
    logic zs[$];

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .pcsource(pcsource), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg)
    );

    always #5 clk = ~clk;

    assign cur = {memread, memwrite, iord, irwrite, alusrca, alusrcb, alucontrol,
                  pcsource, pcen, regwrite, regdst, memtoreg};

    // ---------------- reference model ----------------
    function automatic int lat(input logic [5:0] o);
        case (o)
            LB:             return 8;
            SB, RT, ADDI:   return 7;
            BEQ, JMP:       return 6;
            default:        return 5;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = first fetch byte) of instruction o.
    function automatic ctl_t exp_out(input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input int k);
        ctl_t e;
        e = '0;
        e.alucontrol = 3'b010;
        if (k < 4) begin
            e.memread = 1; e.iord = 1; e.alusrca = 1; e.alusrcb = 2'b01; e.pcen = 1;
            e.irwrite = 4'(1 << k);
        end else if (k == 4) begin
            e.alusrca = 1; e.alusrcb = 2'b11;
        end else begin
            case (o)
                LB:   if (k == 5) e.alusrcb = 2'b10;
                      else if (k == 6) e.memread = 1;
                      else begin e.regwrite = 1; e.regdst = 1; end
                SB:   if (k == 5) e.alusrcb = 2'b10; else e.memwrite = 1;
                RT:   if (k == 5) e.alucontrol = alu_ref(f);
                      else begin e.regwrite = 1; e.memtoreg = 1; end
                BEQ:  begin e.alucontrol = 3'b110; e.pcsource = 2'b01; e.pcen = z; end
                JMP:  begin e.pcen = 1; e.pcsource = 2'b10; end
                ADDI: if (k == 5) e.alusrcb = 2'b10;
                      else begin e.regwrite = 1; e.regdst = 1; e.memtoreg = 1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Runs one instruction starting in FETCH1 and records outputs of every
    // cycle plus the following FETCH1 (obs[lat]). Ends in that FETCH1.
    task automatic capture(input logic [5:0] o, input logic [5:0] f,
                           input bit rand_zero, input logic zv);
        int n;
        n = lat(o);
        obs.delete();
        zs.delete();
        op = o;
        funct = f;
        for (int k = 0; k <= n; k++) begin
            zero = rand_zero ? 1'($urandom_range(0, 1)) : zv;
            #1;
            obs.push_back(cur);
            zs.push_back(zero);
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctl_t f1;
        f1 = exp_out(RT, 6'h0, 1'b0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cur !== f1) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", cur, f1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (cur !== 19'b1_0_1_0001_1_01_010_00_1_0_0_0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", cur, 19'b1_0_1_0001_1_01_010_00_1_0_0_0);
        end
    endtask

    task automatic test_reset_mid_lb();
        ctl_t f1;
        f1 = exp_out(RT, 6'h0, 1'b0, 0);
        op = LB;
        funct = '0;
        #1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (memread !== 1'b1 || iord !== 1'b0) begin
            errors++;
            $display("FAIL mid_lb_lbrd: got memread=%b iord=%b expected memread=1 iord=0", memread, iord);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (cur !== f1) begin
            errors++;
            $display("FAIL mid_lb_async: got %b expected %b", cur, f1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (regwrite !== 1'b0 || cur !== f1) begin
            errors++;
            $display("FAIL mid_lb_no_wb: got %b expected %b", cur, f1);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cur !== f1) begin
            errors++;
            $display("FAIL mid_lb_release: got %b expected %b", cur, f1);
        end
    endtask

    task automatic test_rtype_add();
        capture(RT, 6'b100000, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k].irwrite !== 4'(1 << k) || obs[k].pcen !== 1'b1) begin
                errors++;
                $display("FAIL add_fetch%0d: got irwrite=%b pcen=%b expected irwrite=%b pcen=1",
                         k, obs[k].irwrite, obs[k].pcen, 4'(1 << k));
            end
        end
        checks++;
        if (obs[5].alucontrol !== 3'b010) begin
            errors++;
            $display("FAIL add_alu: got %b expected 010", obs[5].alucontrol);
        end
        checks++;
        if ({obs[6].regwrite, obs[6].regdst, obs[6].memtoreg} !== 3'b101) begin
            errors++;
            $display("FAIL add_wr: got rw/rd/mtr=%b expected 101",
                     {obs[6].regwrite, obs[6].regdst, obs[6].memtoreg});
        end
        checks++;
        if (obs[7].irwrite !== 4'b0001) begin
            errors++;
            $display("FAIL add_latency: got irwrite=%b at cycle 7 expected 0001", obs[7].irwrite);
        end
    endtask

    task automatic test_lb();
        capture(LB, $urandom_range(0, 63), 1'b1, 1'b0);
        checks++;
        if (obs[5].alusrcb !== 2'b10) begin
            errors++;
            $display("FAIL lb_memadr: got alusrcb=%b expected 10", obs[5].alusrcb);
        end
        checks++;
        if (obs[6].memread !== 1'b1 || obs[6].iord !== 1'b0) begin
            errors++;
            $display("FAIL lb_rd: got memread=%b iord=%b expected 1 0", obs[6].memread, obs[6].iord);
        end
        checks++;
        if ({obs[7].regwrite, obs[7].regdst, obs[7].memtoreg} !== 3'b110) begin
            errors++;
            $display("FAIL lb_wr: got rw/rd/mtr=%b expected 110",
                     {obs[7].regwrite, obs[7].regdst, obs[7].memtoreg});
        end
        checks++;
        if (obs[8].irwrite !== 4'b0001 || obs[8].memread !== 1'b1) begin
            errors++;
            $display("FAIL lb_latency: got irwrite=%b at cycle 8 expected 0001", obs[8].irwrite);
        end
    endtask

    task automatic test_beq();
        for (int zv = 1; zv >= 0; zv--) begin
            capture(BEQ, 6'h0, 1'b0, 1'(zv));
            checks++;
            if (obs[5].pcen !== 1'(zv) || obs[5].pcsource !== 2'b01 || obs[5].alucontrol !== 3'b110) begin
                errors++;
                $display("FAIL beq_zero%0d: got pcen=%b pcsource=%b alu=%b expected pcen=%0d pcsource=01 alu=110",
                         zv, obs[5].pcen, obs[5].pcsource, obs[5].alucontrol, zv);
            end
        end
        // zero toggled within BEQEX must reach pcen in the same cycle
        op = BEQ;
        repeat (5) @(posedge clk);
        zero = 1'b0;
        #2;
        checks++;
        if (pcen !== 1'b0) begin
            errors++;
            $display("FAIL beq_comb_lo: got pcen=%b expected 0", pcen);
        end
        zero = 1'b1;
        #1;
        checks++;
        if (pcen !== 1'b1) begin
            errors++;
            $display("FAIL beq_comb_hi: got pcen=%b expected 1", pcen);
        end
        @(posedge clk);
        zero = 1'b0;
    endtask

    task automatic test_j_sb();
        capture(JMP, 6'h0, 1'b1, 1'b0);
        checks++;
        if (obs[5].pcen !== 1'b1 || obs[5].pcsource !== 2'b10) begin
            errors++;
            $display("FAIL j_ex: got pcen=%b pcsource=%b expected 1 10", obs[5].pcen, obs[5].pcsource);
        end
        capture(SB, 6'h0, 1'b1, 1'b0);
        checks++;
        if (obs[6].memwrite !== 1'b1 || obs[6].iord !== 1'b0 || obs[6].regwrite !== 1'b0) begin
            errors++;
            $display("FAIL sb_wr: got memwrite=%b iord=%b regwrite=%b expected 1 0 0",
                     obs[6].memwrite, obs[6].iord, obs[6].regwrite);
        end
    endtask

    task automatic test_funct_sweep();
        logic [5:0] fs [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        logic [2:0] ac [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        for (int i = 0; i < 5; i++) begin
            capture(RT, fs[i], 1'b1, 1'b0);
            checks++;
            if (obs[5].alucontrol !== ac[i]) begin
                errors++;
                $display("FAIL funct_%b: got %b expected %b", fs[i], obs[5].alucontrol, ac[i]);
            end
        end
    endtask

    task automatic test_undefined_op();
        capture(6'b111111, 6'h0, 1'b1, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (obs[k] !== exp_out(6'b111111, 6'h0, 1'b0, (k < 5) ? k : 0)) begin
                errors++;
                $display("FAIL undef_c%0d: got %b expected %b", k, obs[k],
                         exp_out(6'b111111, 6'h0, 1'b0, (k < 5) ? k : 0));
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{LB, SB, RT, BEQ, JMP, ADDI};
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] o, f;
        int n, bad, rw, mw;
        ctl_t e;
        for (int t = 0; t < 60; t++) begin
            o = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            f = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            capture(o, f, 1'b1, 1'b0);
            n = lat(o);
            bad = 0; rw = 0; mw = 0;
            for (int k = 0; k <= n; k++) begin
                e = exp_out(o, f, zs[k], (k < n) ? k : 0);
                checks++;
                if (obs[k] !== e) begin
                    errors++;
                    $display("FAIL rand_t%0d_op%b_f%b_c%0d: got %b expected %b", t, o, f, k, obs[k], e);
                end
                if (obs[k].memread && obs[k].memwrite) bad++;
                if (k < n) begin
                    rw += int'(obs[k].regwrite);
                    mw += int'(obs[k].memwrite);
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_t%0d_strobes: got %0d cycles with memread&memwrite expected 0", t, bad);
            end
            checks++;
            if (rw != ((o == LB || o == RT || o == ADDI) ? 1 : 0) || mw != ((o == SB) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_t%0d_pulses: got regwrite=%0d memwrite=%0d for op %b", t, rw, mw, o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_lb();
        test_rtype_add();
        test_lb();
        test_beq();
        test_j_sb();
        test_funct_sweep();
        test_undefined_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
